timer_display: RTL and testbench

//  Downstream consumer of the game countdown timer. Takes the BCD minute/second

---
 rtl/timer_display.sv | 156 +++++++++++++++
 tb/tb_timer_display.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_display.sv
// Four-digit multiplexed 7-segment driver for the countdown timer, shown as " M.SS".
// Optional time-up blinking is built only when TIMEUP_BLINK_EN is defined.
module timer_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min,
  input  logic [3:0] sec1,
  input  logic [3:0] sec2,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       time_up
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic [1:0]    idx, idx_n;
  logic [3:0]    sh_min, sh_sec1, sh_sec2;
  logic [3:0]    sh_min_n, sh_sec1_n, sh_sec2_n;
  logic          scan_tc;
  logic          blank;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic          zero_n;

  // Shadow is refreshed only on the 3->0 wrap so a frame never mixes two input values.
  always_comb begin
    scan_tc    = (scan_cnt == SW'(SCAN_DIV - 1));
    scan_cnt_n = scan_tc ? '0 : scan_cnt + SW'(1);
    idx_n      = scan_tc ? idx + 2'd1 : idx;
    sh_min_n   = sh_min;
    sh_sec1_n  = sh_sec1;
    sh_sec2_n  = sh_sec2;
    if (scan_tc && idx == 2'd3) begin
      sh_min_n  = min;
      sh_sec1_n = sec1;
      sh_sec2_n = sec2;
    end
    zero_n = (min == 4'd0) && (sec1 == 4'd0) && (sec2 == 4'd0);
  end

  always_comb begin
    an_n  = 4'b1110;
    seg_n = decode(sh_sec2_n);
    dp_n  = 1'b1;
    case (idx_n)
      2'd0: begin
        an_n  = 4'b1110;
        seg_n = decode(sh_sec2_n);
      end
      2'd1: begin
        an_n  = 4'b1101;
        seg_n = decode(sh_sec1_n);
      end
      2'd2: begin
        an_n  = 4'b1011;
        seg_n = decode(sh_min_n);
        dp_n  = 1'b0;
      end
      default: begin
        an_n  = 4'b0111;
        seg_n = 7'h7F;
      end
    endcase
    if (blank) an_n = 4'b1111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      sh_min   <= 4'd2;
      sh_sec1  <= 4'd0;
      sh_sec2  <= 4'd0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
      dp       <= 1'b1;
      time_up  <= 1'b0;
    end else begin
      scan_cnt <= scan_cnt_n;
      idx      <= idx_n;
      sh_min   <= sh_min_n;
      sh_sec1  <= sh_sec1_n;
      sh_sec2  <= sh_sec2_n;
      an       <= an_n;
      seg      <= seg_n;
      dp       <= dp_n;
      time_up  <= zero_n;
    end
  end

`ifdef TIMEUP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_phase, blink_phase_n;

  // Blanking follows the next-state phase so it lands on the same edge as the toggle.
  always_comb begin
    blink_cnt_n   = '0;
    blink_phase_n = 1'b0;
    if (time_up) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt_n   = '0;
        blink_phase_n = ~blink_phase;
      end else begin
        blink_cnt_n   = blink_cnt + BW'(1);
        blink_phase_n = blink_phase;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
    end
  end

  assign blank = blink_phase_n;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_timer_display.sv
// Bench for timer_display with SCAN_DIV=4, BLINK_DIV=8: frame vectors, snapshot timing,
// undefined-digit decode, time-up latency, blinking and asynchronous reset.
module tb_timer_display;

  logic       clk;
  logic       rst;
  logic [3:0] min, sec1, sec2;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       time_up;

  int checks = 0;
  int errors = 0;

  // {an, seg, dp}
  logic [11:0] exp_q[$];

  typedef struct {
    logic [3:0] m;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [6:0] e0;
    logic [6:0] e1;
    logic [6:0] e2;
  } vec_t;

  vec_t vecs[5];

  timer_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .min(min), .sec1(sec1), .sec2(sec2),
    .an(an), .seg(seg), .dp(dp), .time_up(time_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_an"}, {8'd0, an}, {8'd0, 4'b1110});
    check({name, "_seg"}, {5'd0, seg}, {5'd0, 7'b1000000});
    check({name, "_dp"}, {11'd0, dp}, 12'd1);
    check({name, "_time_up"}, {11'd0, time_up}, 12'd0);
  endtask

  task automatic set_inputs(input logic [3:0] m, input logic [3:0] s1, input logic [3:0] s2);
    min  = m;
    sec1 = s1;
    sec2 = s2;
  endtask

  // Each digit stays lit for four cycles, so a frame is sixteen expected entries.
  task automatic push_frame(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b1110, e0, 1'b1});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b1101, e1, 1'b1});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b1011, e2, 1'b0});
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b0111, 7'h7F, 1'b1});
  endtask

  task automatic check_one(input string name);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {an, seg, dp}, e);
    end
  endtask

  // Returns at the negedge where digit 0 is first shown after digit 3.
  task automatic wait_frame_start(input string name);
    logic [3:0] prev;
    bit found;
    prev  = an;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
      prev = an;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s no frame start within 40 cycles an=%b", name, an);
    end
  endtask

  initial begin
    int blank_cnt;
    int exp_blank;

    vecs[0] = '{4'd1, 4'd3, 4'd5, 7'b0010010, 7'b0110000, 7'b1111001};
    vecs[1] = '{4'd9, 4'd5, 4'd9, 7'b0010000, 7'b0010010, 7'b0010000};
    vecs[2] = '{4'd2, 4'd4, 4'd8, 7'b0000000, 7'b0011001, 7'b0100100};
    vecs[3] = '{4'hF, 4'd0, 4'hA, 7'b0111111, 7'b1000000, 7'b0111111};
    vecs[4] = '{4'd7, 4'd0, 4'd6, 7'b0000010, 7'b1000000, 7'b1111000};

    rst = 1'b1;
    set_inputs(4'd1, 4'd3, 4'd5);
    #1;
    check_reset_state("power_on_reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run takes effect immediately, without a clock edge.
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("mid_run_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      set_inputs(vecs[v].m, vecs[v].s1, vecs[v].s2);
      wait_frame_start($sformatf("vec%0d_sync", v));
      push_frame(vecs[v].e0, vecs[v].e1, vecs[v].e2);
      check_one($sformatf("vec%0d_c0", v));
      for (int c = 1; c < 16; c++) begin
        @(negedge clk);
        check_one($sformatf("vec%0d_c%0d", v, c));
      end
    end

    // Inputs changing mid-frame stay hidden until the next 3->0 wrap.
    set_inputs(4'd1, 4'd3, 4'd5);
    wait_frame_start("snap_sync");
    push_frame(7'b0010010, 7'b0110000, 7'b1111001);
    push_frame(7'b0011001, 7'b0110000, 7'b1111001);
    check_one("snap_c0");
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      if (c == 6) set_inputs(4'd1, 4'd3, 4'd4);
      check_one($sformatf("snap_c%0d", c));
    end

    // Time-up: one cycle of latency from live inputs.
    set_inputs(4'd0, 4'd0, 4'd1);
    repeat (2) @(negedge clk);
    check("tu_low_at_0_01", {11'd0, time_up}, 12'd0);
    set_inputs(4'd0, 4'd0, 4'd0);
    #1 check("tu_before_edge", {11'd0, time_up}, 12'd0);
    @(negedge clk);
    check("tu_high", {11'd0, time_up}, 12'd1);

`ifdef TIMEUP_BLINK_EN
    exp_blank = 16;
`else
    exp_blank = 0;
`endif
    repeat (2) @(negedge clk);
    blank_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (an == 4'b1111) blank_cnt++;
    end
    check("blank_cycles_of_32", 12'(blank_cnt), 12'(exp_blank));
    check("tu_held", {11'd0, time_up}, 12'd1);

    // Reset while time-up is active clears the blink phase too.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("reset_during_blink");
    @(negedge clk);
    rst = 1'b0;
    blank_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (an == 4'b1111) blank_cnt++;
    end
    check("no_blank_after_reset", 12'(blank_cnt), 12'd0);
    check("tu_after_reset", {11'd0, time_up}, 12'd1);

    blank_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (an == 4'b1111) blank_cnt++;
    end
    check("blank_resumes_of_16", 12'(blank_cnt), 12'(exp_blank / 2));

    // Leaving 0:00 drops time_up and stops blinking.
    set_inputs(4'd1, 4'd0, 4'd0);
    @(negedge clk);
    check("tu_released", {11'd0, time_up}, 12'd0);
    blank_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (an == 4'b1111) blank_cnt++;
    end
    check("no_blank_after_release", 12'(blank_cnt), 12'd0);

    wait_frame_start("final_sync");
    push_frame(7'b1000000, 7'b1000000, 7'b1111001);
    check_one("final_c0");
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      check_one($sformatf("final_c%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
